// File: rtl/sarray_row_feeder.sv
// sarray_row_feeder: left-edge driver for one systolic-array row.
// Sequences a per-tile command into an optional C preload followed by a
// skewed A operand stream, tagging each beat with type, count and precision.
// All outputs are registered; the array applies no backpressure.

`ifndef SARRAY_W
`define SARRAY_W 4
`endif
`ifndef PE_INPUT_DATA_WIDTH
`define PE_INPUT_DATA_WIDTH 16
`endif
`ifndef TMMA_CNT_WIDTH
`define TMMA_CNT_WIDTH 8
`endif
`ifndef TMMA_PRECISION_WIDTH
`define TMMA_PRECISION_WIDTH 2
`endif
`ifndef PE_DATA_TYPE_A
`define PE_DATA_TYPE_A 1'b0
`endif
`ifndef PE_DATA_TYPE_C
`define PE_DATA_TYPE_C 1'b1
`endif

module sarray_row_feeder #(
  parameter int Y        = 0,
  parameter int SARRAY_W = `SARRAY_W,
  parameter int DW       = `PE_INPUT_DATA_WIDTH,
  parameter int CW       = `TMMA_CNT_WIDTH,
  parameter int PW       = `TMMA_PRECISION_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [CW-1:0] cmd_k_i,
  input  logic          cmd_load_c_i,
  input  logic [PW-1:0] cmd_precision_i,
  input  logic          c_valid_i,
  output logic          c_ready_o,
  input  logic [DW-1:0] c_data_i,
  input  logic          go_i,
  input  logic          a_valid_i,
  output logic          a_ready_o,
  input  logic [DW-1:0] a_data_i,
  output logic          left_data_valid_o,
  output logic [CW-1:0] left_data_cnt_o,
  output logic          left_data_type_o,
  output logic [PW-1:0] left_precision_o,
  output logic [DW-1:0] left_data_o,
  output logic          done_o,
  output logic          underflow_o
);

  // Skew counter must hold Y; keep at least one bit when the row has no skew.
  localparam int SKW = (Y > 0) ? $clog2(Y + 1) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(SARRAY_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_C, S_WAIT_GO, S_SKEW, S_STREAM_A, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [PW-1:0]   prec_q, prec_d;
  logic [CW-1:0]   idx_q, idx_d;      // C handshake index, then A slot index
  logic [SKW-1:0]  skew_q, skew_d;
  logic            underflow_q, underflow_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            c_ready_q, c_ready_d;
  logic            a_ready_q, a_ready_d;
  logic            done_q, done_d;
  logic            lv_q, lv_d;
  logic [CW-1:0]   lcnt_q, lcnt_d;
  logic            ltype_q, ltype_d;
  logic [PW-1:0]   lprec_q, lprec_d;
  logic [DW-1:0]   ldata_q, ldata_d;

  // Next-state and next-beat logic; handshake strobes are registered copies
  // of the upcoming state so they line up with the state they qualify.
  always_comb begin
    // NOTE: every _d signal is defaulted first so no path through the case
    // leaves it unassigned and infers a latch.
    state_d     = state_q;
    k_d         = k_q;
    prec_d      = prec_q;
    idx_d       = idx_q;
    skew_d      = skew_q;
    underflow_d = underflow_q;
    lv_d        = 1'b0;
    lcnt_d      = '0;
    ltype_d     = 1'b0;
    lprec_d     = '0;
    ldata_d     = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_ready_q && cmd_valid_i) begin
          k_d         = cmd_k_i;
          prec_d      = cmd_precision_i;
          underflow_d = 1'b0;
          idx_d       = '0;
          state_d     = cmd_load_c_i ? S_LOAD_C : S_WAIT_GO;
        end
      end
      S_LOAD_C: begin
        if (c_valid_i) begin
          // cnt=1 lands on the farthest PE, cnt=SARRAY_W on column 0.
          lv_d    = 1'b1;
          ltype_d = `PE_DATA_TYPE_C;
          lcnt_d  = idx_q + CW'(1);
          lprec_d = prec_q;
          ldata_d = c_data_i;
          if (idx_q == LAST_C) begin
            idx_d   = '0;
            state_d = S_WAIT_GO;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      S_WAIT_GO: begin
        if (go_i) begin
          idx_d = '0;
          if (k_q == '0) begin
            state_d = S_DONE;
          end else if (Y == 0) begin
            state_d = S_STREAM_A;
          end else begin
            state_d = S_SKEW;
            skew_d  = SKW'(Y);
          end
        end
      end
      S_SKEW: begin
        if (skew_q == SKW'(1)) state_d = S_STREAM_A;
        else                   skew_d  = skew_q - SKW'(1);
      end
      S_STREAM_A: begin
        // A missing operand burns its slot so the row stays aligned with
        // the column stream; the miss is remembered in underflow.
        if (a_valid_i) begin
          lv_d    = 1'b1;
          ltype_d = `PE_DATA_TYPE_A;
          lcnt_d  = idx_q;
          lprec_d = prec_q;
          ldata_d = a_data_i;
        end else begin
          underflow_d = 1'b1;
        end
        if (idx_q == k_q - CW'(1)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    c_ready_d   = (state_d == S_LOAD_C);
    a_ready_d   = (state_d == S_STREAM_A);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers; reset discards any in-flight tile.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      prec_q      <= '0;
      idx_q       <= '0;
      skew_q      <= '0;
      underflow_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      c_ready_q   <= 1'b0;
      a_ready_q   <= 1'b0;
      done_q      <= 1'b0;
      lv_q        <= 1'b0;
      lcnt_q      <= '0;
      ltype_q     <= 1'b0;
      lprec_q     <= '0;
      ldata_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      prec_q      <= prec_d;
      idx_q       <= idx_d;
      skew_q      <= skew_d;
      underflow_q <= underflow_d;
      cmd_ready_q <= cmd_ready_d;
      c_ready_q   <= c_ready_d;
      a_ready_q   <= a_ready_d;
      done_q      <= done_d;
      lv_q        <= lv_d;
      lcnt_q      <= lcnt_d;
      ltype_q     <= ltype_d;
      lprec_q     <= lprec_d;
      ldata_q     <= ldata_d;
    end
  end

  assign cmd_ready_o       = cmd_ready_q;
  assign c_ready_o         = c_ready_q;
  assign a_ready_o         = a_ready_q;
  assign done_o            = done_q;
  assign underflow_o       = underflow_q;
  assign left_data_valid_o = lv_q;
  assign left_data_cnt_o   = lcnt_q;
  assign left_data_type_o  = ltype_q;
  assign left_precision_o  = lprec_q;
  assign left_data_o       = ldata_q;

endmodule

// File: doc/sarray_row_feeder.md
# sarray_row_feeder

Drives the left edge of one systolic-array row: emits the C-preload beats and the A operand stream that the PE row consumes on its `left_*` inputs. Sits between the operand buffer/tile controller and PE column 0 of row `Y`. It sequences a per-tile command, tags beats with type, count and precision, and applies the row's systolic skew. Outputs are fully registered. There is no backpressure from the array.

## Interface
- `Y`, 0, row index; sets the skew delay in cycles.
- `SARRAY_W`, `` `SARRAY_W ``, array width in PEs.
- `DW`, `` `PE_INPUT_DATA_WIDTH ``, data width.
- `CW`, `` `TMMA_CNT_WIDTH ``, cnt width.
- `PW`, `` `TMMA_PRECISION_WIDTH ``, precision width.

Clock and reset:
- One clock `clk`. Reset `rst` is asynchronous and active-high.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  async active-high reset
- `cmd_valid_i`  in  1  tile command valid
- `cmd_ready_o`  out  1  high only in IDLE
- `cmd_k_i`  in  CW  number of A beats (K)
- `cmd_load_c_i`  in  1  perform C preload first
- `cmd_precision_i`  in  PW  precision tag for all beats
- `c_valid_i` / `c_ready_o` / `c_data_i`  in/out/in  1/1/DW  C preload stream
- `go_i`  in  1  array-wide start strobe for the A phase
- `a_valid_i` / `a_ready_o` / `a_data_i`  in/out/in  1/1/DW  A operand stream
- `left_data_valid_o`  out  1  beat valid to PE row
- `left_data_cnt_o`  out  CW  beat count
- `left_data_type_o`  out  1  `` `PE_DATA_TYPE_A `` or `` `PE_DATA_TYPE_C ``
- `left_precision_o`  out  PW  captured precision
- `left_data_o`  out  DW  beat data
- `done_o`  out  1  one-cycle tile-complete pulse
- `underflow_o`  out  1  sticky: A slot missed

## Operation

States: IDLE, LOAD_C, WAIT_GO, SKEW, STREAM_A, DONE.

- **IDLE**
  - `cmd_ready_o`=1.
  - When `cmd_valid_i` is high: capture K, load_c and precision, and clear `underflow_o`.
  - Next state is LOAD_C if load_c is set, else WAIT_GO.
- **LOAD_C**
  - `c_ready_o`=1.
  - Handshake j (0..SARRAY_W-1) emits a C-type beat with cnt=j+1 and data=`c_data_i`.
  - cnt=1 targets the farthest PE (column SARRAY_W-1); cnt=SARRAY_W targets column 0.
  - Idle cycles (no `c_valid_i`) emit valid=0.
  - After handshake SARRAY_W-1, go to WAIT_GO.
- **WAIT_GO**
  - Wait for `go_i`.
  - On `go_i`: if K==0, go to DONE. Else if Y==0, go to STREAM_A. Else go to SKEW with skew counter=Y.
- **SKEW**
  - Count down Y cycles, then go to STREAM_A.
  - Outputs valid=0 throughout.
- **STREAM_A**
  - Exactly K slots, one per cycle; `a_ready_o`=1 in every slot.
  - Slot i with `a_valid_i`=1: emit an A-type beat with cnt=i and data=`a_data_i`.
  - Slot i with `a_valid_i`=0: emit valid=0 and set `underflow_o`. The slot index still advances, so alignment with the top stream is preserved.
  - After slot K-1, go to DONE.
- **DONE**
  - `done_o`=1 for one cycle, then go to IDLE.

General rules:
- `go_i` is ignored outside WAIT_GO.
- `c_ready_o` and `a_ready_o` are 0 outside their states.
- Precision comes from the captured command for every beat.
- cnt in A beats is i truncated to CW bits, so K ≤ 2^CW−1.
- Non-valid cycles drive type, cnt and data to 0.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, `underflow_o` 0. Reset is effective immediately at any point, and any in-flight tile is discarded.
- Beat latency: a beat appears on `left_*` exactly 1 cycle after its accepting cycle (registered output).
- Command accepted at cycle t:
  - With load_c, LOAD_C starts at t+1.
  - Without load_c, WAIT_GO starts at t+1.
- `go_i` sampled at cycle g:
  - STREAM_A occupies cycles g+1+Y … g+Y+K.
  - A beat i is on the output at g+2+Y+i.
  - `done_o` is high at g+1+Y+K, the same cycle as the last A beat.
  - With K==0, `done_o` is high at g+1.
- Back-to-back tiles: the next command is accepted at the earliest the cycle after `done_o`.
- `go_i` coincident with entry into WAIT_GO is not seen; it must arrive while in WAIT_GO.

## Test plan
- **Reset mid-stream.** SARRAY_W=4, Y=0. Assert `rst` during STREAM_A slot 2 → all outputs 0 that cycle, and `cmd_ready_o`=1 after release.
- **C preload.** SARRAY_W=4, Y=1, load_c=1, K=3, precision=2. Four C beats (1 gap cycle) → beats C with cnt 1,2,3,4, precision 2, one valid=0 gap. `go_i` at g → A cnt 0,1,2 at g+3, g+4, g+5. `done_o` at g+5.
- **Skew and no preload.** Y=3, load_c=0, K=5. `go_i` at g → no valid before g+5. A beats at g+5 … g+9, then `done_o` at g+9.
- **Underflow.** K=4, Y=0, `a_valid_i` low in slot 1 → output valid 1,0,1,1 with cnt 0,–,2,3. `underflow_o`=1 and stays 1 until the next command is accepted.
- **K=0.** K=0, load_c=0 → no A beats, `done_o` 1 cycle after `go_i`. `go_i` pulses before WAIT_GO are ignored.
- **Back-to-back commands.** Two tiles back to back → `cmd_ready_o` low from accept until the cycle after `done_o`. The second tile's precision appears only on its own beats.
